dice_pred_rf_bank_ctrl: RTL and testbench

DICE_PRED_RF_BANK_CTRL -- requirements
Module: dice_pred_rf_bank_ctrl

---
 rtl/dice_rf_pkg.sv | 15 +
 rtl/dice_pred_rf_bank_ctrl_if.sv | 44 ++++
 rtl/dice_rf_delay_line.sv | 59 +++++
 rtl/dice_pred_rf_bank_ctrl.sv | 158 +++++++++++++++
 tb/tb_dice_pred_rf_bank_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dice_rf_pkg.sv
// Shared types and helpers for the predicate register-file bank controller.
package dice_rf_pkg;

    // Bulk-clear controller states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } rf_state_e;

    // Width of a per-port latency select for a delay line of the given depth bound.
    function automatic int unsigned lat_width(input int unsigned max_stage);
        return $clog2(max_stage);
    endfunction

endpackage

// File: rtl/dice_pred_rf_bank_ctrl_if.sv
// Request/response bundle of the predicate register-file bank controller.
interface dice_pred_rf_bank_ctrl_if
    import dice_rf_pkg::*;
#(
    parameter int unsigned NUM_PORTS         = 16,
    parameter int unsigned DATA_WIDTH        = 1,
    parameter int unsigned NUM_TID           = 512,
    parameter int unsigned MAX_IO_PIPE_STAGE = 8
);
    localparam int unsigned AW   = $clog2(NUM_TID);
    localparam int unsigned LATW = lat_width(MAX_IO_PIPE_STAGE);

    logic                             clr_req;
    logic                             clr_busy;
    logic                             clr_done;
    logic [NUM_PORTS-1:0]             rd_en;
    logic [AW-1:0]                    rd_tid;
    logic [NUM_PORTS*DATA_WIDTH-1:0]  rd_data;
    logic [NUM_PORTS-1:0]             rd_valid;
    logic [NUM_PORTS-1:0]             wr_en;
    logic [AW-1:0]                    wr_tid;
    logic [NUM_PORTS*DATA_WIDTH-1:0]  wr_data;
    logic [NUM_PORTS*AW-1:0]          rd_ovr_mask;
    logic [NUM_PORTS*AW-1:0]          rd_ovr_addr;
    logic [NUM_PORTS*AW-1:0]          wr_ovr_mask;
    logic [NUM_PORTS*AW-1:0]          wr_ovr_addr;
    logic [NUM_PORTS*LATW-1:0]        input_latency;
    logic [NUM_PORTS*LATW-1:0]        output_latency;

    modport master (
        output clr_req, rd_en, rd_tid, wr_en, wr_tid, wr_data,
               rd_ovr_mask, rd_ovr_addr, wr_ovr_mask, wr_ovr_addr,
               input_latency, output_latency,
        input  clr_busy, clr_done, rd_data, rd_valid
    );

    modport slave (
        input  clr_req, rd_en, rd_tid, wr_en, wr_tid, wr_data,
               rd_ovr_mask, rd_ovr_addr, wr_ovr_mask, wr_ovr_addr,
               input_latency, output_latency,
        output clr_busy, clr_done, rd_data, rd_valid
    );

endinterface

// File: rtl/dice_rf_delay_line.sv
// Fixed-depth valid+data shift register with a selectable output tap.
// Tap 0 is the undelayed input; tap k is the k-th register stage, so a
// latency change only moves the tap and never disturbs entries in flight.
module dice_rf_delay_line
    import dice_rf_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned MAX_PIPE_STAGE = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush_i,
    input  logic [lat_width(MAX_PIPE_STAGE)-1:0]  lat_i,
    input  logic                                  in_valid_i,
    input  logic [WIDTH-1:0]                      in_data_i,
    output logic                                  tap_valid_c_o,
    output logic [WIDTH-1:0]                      tap_data_c_o
);
    localparam int unsigned NSTG = MAX_PIPE_STAGE - 1;
    localparam int unsigned LATW = lat_width(MAX_PIPE_STAGE);

    logic [NSTG-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [NSTG];
    logic [LATW-1:0]  tap_idx_c;

    // Valid shift chain; flush wipes every stage at once.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid_i;
            for (int k = 1; k < int'(NSTG); k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // Data shift chain; qualified only by the valid chain.
    always_ff @(posedge clk) begin
        dat_q[0] <= in_data_i;
        for (int k = 1; k < int'(NSTG); k++) begin
            dat_q[k] <= dat_q[k-1];
        end
    end

    assign tap_idx_c = lat_i - LATW'(1);

    // Tap select; nothing leaves the line while it is being flushed.
    always_comb begin
        tap_valid_c_o = in_valid_i;
        tap_data_c_o  = in_data_i;
        if (lat_i != '0) begin
            tap_valid_c_o = vld_q[tap_idx_c];
            tap_data_c_o  = dat_q[tap_idx_c];
        end
        tap_valid_c_o = tap_valid_c_o & ~flush_i;
    end

endmodule

// File: rtl/dice_pred_rf_bank_ctrl.sv
// Multi-port predicate register-file bank controller: per-port 1R1W banks with
// address override, programmable write/read delay lines and a bulk clear sweep.
module dice_pred_rf_bank_ctrl
    import dice_rf_pkg::*;
#(
    parameter int unsigned NUM_PORTS         = 16,
    parameter int unsigned DATA_WIDTH        = 1,
    parameter int unsigned NUM_TID           = 512,
    parameter int unsigned MAX_IO_PIPE_STAGE = 8,
    parameter logic        CLR_VALUE         = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    dice_pred_rf_bank_ctrl_if.slave  bus
);
    localparam int unsigned AW   = $clog2(NUM_TID);
    localparam int unsigned LATW = lat_width(MAX_IO_PIPE_STAGE);
    localparam int unsigned DW   = DATA_WIDTH;
    localparam int unsigned WPAY = AW + DW;

    rf_state_e       state_q;
    logic [AW-1:0]   idx_q;
    logic            clr_busy_q;
    logic            clr_done_q;
    logic            flush_c;
    logic            sweep_c;

    logic [NUM_PORTS-1:0]    rd_valid_all;
    logic [NUM_PORTS*DW-1:0] rd_data_all;

    // Delay lines drop their contents for the whole sweep, including the
    // cycle the clear is accepted.
    assign sweep_c = (state_q == ST_SWEEP);
    assign flush_c = sweep_c || ((state_q == ST_IDLE) && bus.clr_req);

    // Clear-sweep FSM with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SWEEP;
            idx_q      <= '0;
            clr_busy_q <= 1'b1;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state_q    <= ST_SWEEP;
                        idx_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (idx_q == AW'(NUM_TID - 1)) begin
                        state_q    <= ST_IDLE;
                        idx_q      <= '0;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    idx_q      <= '0;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_port
        logic [AW-1:0]   rd_addr_c;
        logic [AW-1:0]   wr_addr_c;
        logic            wr_vld_c;
        logic [WPAY-1:0] wr_pay_c;
        logic [AW-1:0]   wr_cmt_addr_c;
        logic [DW-1:0]   wr_cmt_data_c;
        logic [DW-1:0]   rd_raw_c;
        logic            rd_tap_vld_c;
        logic [DW-1:0]   rd_tap_data_c;
        logic            rd_valid_q;
        logic [DW-1:0]   rd_data_q;
        logic [DW-1:0]   mem_q [NUM_TID];

        // Override bits replace the matching thread-id bits.
        assign rd_addr_c = (bus.rd_tid & ~bus.rd_ovr_mask[p*AW +: AW])
                         | (bus.rd_ovr_addr[p*AW +: AW] & bus.rd_ovr_mask[p*AW +: AW]);
        assign wr_addr_c = (bus.wr_tid & ~bus.wr_ovr_mask[p*AW +: AW])
                         | (bus.wr_ovr_addr[p*AW +: AW] & bus.wr_ovr_mask[p*AW +: AW]);

        dice_rf_delay_line #(
            .WIDTH          (WPAY),
            .MAX_PIPE_STAGE (MAX_IO_PIPE_STAGE)
        ) u_wr_dly (
            .clk           (clk),
            .rst           (rst),
            .flush_i       (flush_c),
            .lat_i         (bus.input_latency[p*LATW +: LATW]),
            .in_valid_i    (bus.wr_en[p]),
            .in_data_i     ({wr_addr_c, bus.wr_data[p*DW +: DW]}),
            .tap_valid_c_o (wr_vld_c),
            .tap_data_c_o  (wr_pay_c)
        );

        assign wr_cmt_addr_c = wr_pay_c[WPAY-1 -: AW];
        assign wr_cmt_data_c = wr_pay_c[DW-1:0];

        // Bank storage: sweep writes take priority over committed writes.
        always_ff @(posedge clk) begin
            if (sweep_c) begin
                mem_q[idx_q] <= {DW{CLR_VALUE}};
            end else if (wr_vld_c) begin
                mem_q[wr_cmt_addr_c] <= wr_cmt_data_c;
            end
        end

        // Write-first: a write committing this edge to the same entry wins.
        assign rd_raw_c = (wr_vld_c && (wr_cmt_addr_c == rd_addr_c)) ? wr_cmt_data_c
                                                                     : mem_q[rd_addr_c];

        dice_rf_delay_line #(
            .WIDTH          (DW),
            .MAX_PIPE_STAGE (MAX_IO_PIPE_STAGE)
        ) u_rd_dly (
            .clk           (clk),
            .rst           (rst),
            .flush_i       (flush_c),
            .lat_i         (bus.output_latency[p*LATW +: LATW]),
            .in_valid_i    (bus.rd_en[p]),
            .in_data_i     (rd_raw_c),
            .tap_valid_c_o (rd_tap_vld_c),
            .tap_data_c_o  (rd_tap_data_c)
        );

        // Read output register; data holds its last valid value.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_valid_q <= 1'b0;
                rd_data_q  <= '0;
            end else begin
                rd_valid_q <= rd_tap_vld_c;
                if (rd_tap_vld_c) begin
                    rd_data_q <= rd_tap_data_c;
                end
            end
        end

        assign rd_valid_all[p]           = rd_valid_q;
        assign rd_data_all[p*DW +: DW]   = rd_data_q;
    end

    assign bus.rd_valid = rd_valid_all;
    assign bus.rd_data  = rd_data_all;
    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;

endmodule

// File: tb/tb_dice_pred_rf_bank_ctrl.sv
// Directed bench for the predicate register-file bank controller.
module tb_dice_pred_rf_bank_ctrl;

    localparam int unsigned NP   = 16;
    localparam int unsigned DW   = 1;
    localparam int unsigned NT   = 512;
    localparam int unsigned MAXS = 8;
    localparam int unsigned AW   = 9;
    localparam int unsigned LATW = 3;

    logic clk = 1'b0;
    logic rst;

    initial forever #5 clk = ~clk;

    dice_pred_rf_bank_ctrl_if #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .NUM_TID(NT), .MAX_IO_PIPE_STAGE(MAXS)
    ) bus ();

    dice_pred_rf_bank_ctrl #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .NUM_TID(NT),
        .MAX_IO_PIPE_STAGE(MAXS), .CLR_VALUE(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int port;
        int in_lat;
        int out_lat;
        int wr_tid;
        int wr_data;
        int wr_mask;
        int wr_addr;
        int rd_tid;
        int rd_mask;
        int rd_addr;
        int rd_at;
        int exp_data;
    } vec_t;

    vec_t vecs [10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_req();
        bus.clr_req = 1'b0;
        bus.rd_en   = '0;
        bus.wr_en   = '0;
        bus.rd_tid  = '0;
        bus.wr_tid  = '0;
        bus.wr_data = '0;
    endtask

    task automatic clear_cfg();
        bus.rd_ovr_mask    = '0;
        bus.rd_ovr_addr    = '0;
        bus.wr_ovr_mask    = '0;
        bus.wr_ovr_addr    = '0;
        bus.input_latency  = '0;
        bus.output_latency = '0;
    endtask

    // Runs until clr_busy drops (bounded); optionally pokes a clr_req plus a
    // port-11 write at sweep cycle poke_at. Ends at the clr_done cycle.
    task automatic wait_sweep(input string name, input int exp_cycles, input int poke_at);
        int n = 0;
        int early_done = 0;
        int rv = 0;
        while (bus.clr_busy === 1'b1 && n < 2000) begin
            if (bus.clr_done !== 1'b0) early_done++;
            if (bus.rd_valid !== '0) rv++;
            bus.clr_req = (n == poke_at);
            bus.wr_en   = '0;
            if (n == poke_at) begin
                bus.wr_en[11]   = 1'b1;
                bus.wr_tid      = 9'd2;
                bus.wr_data[11] = 1'b0;
            end
            n++;
            tick();
        end
        idle_req();
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
        check({name, "_done_pulse"}, 32'(bus.clr_done), 32'd1);
        check({name, "_no_done_while_busy"}, 32'(early_done), 32'd0);
        check({name, "_rd_valid_quiet"}, 32'(rv), 32'd0);
    endtask

    // Reads every entry of one port back-to-back and expects all ones.
    task automatic read_all(input int port, input string name);
        int bad = 0;
        for (int t = 0; t < int'(NT); t++) begin
            bus.rd_en       = '0;
            bus.rd_en[port] = 1'b1;
            bus.rd_tid      = 9'(t);
            tick();
            if (bus.rd_valid[port] !== 1'b1 || bus.rd_data[port] !== 1'b1) bad++;
        end
        bus.rd_en = '0;
        tick();
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic read_one(input int port, input int tid, input logic exp, input string name);
        logic [NP-1:0] ev;
        ev = '0;
        ev[port] = 1'b1;
        bus.rd_en       = '0;
        bus.rd_en[port] = 1'b1;
        bus.rd_tid      = 9'(tid);
        tick();
        bus.rd_en = '0;
        check({name, "_valid"}, 32'(bus.rd_valid), 32'(ev));
        check({name, "_data"}, 32'(bus.rd_data[port]), 32'(exp));
    endtask

    task automatic write_one(input int port, input int tid, input logic d);
        bus.wr_en         = '0;
        bus.wr_en[port]   = 1'b1;
        bus.wr_tid        = 9'(tid);
        bus.wr_data[port] = d;
        tick();
        bus.wr_en = '0;
    endtask

    // Write at cycle 0, read at cycle rd_at; valid expected only at rd_at+1+out_lat.
    task automatic run_vec(input int i, input vec_t v);
        int            exp_cyc;
        int            bad;
        logic          got;
        logic          held;
        logic [NP-1:0] ev;
        exp_cyc = v.rd_at + 1 + v.out_lat;
        bad  = 0;
        got  = 1'bx;
        held = 1'bx;
        bus.input_latency[v.port*LATW +: LATW]  = 3'(v.in_lat);
        bus.output_latency[v.port*LATW +: LATW] = 3'(v.out_lat);
        bus.wr_ovr_mask[v.port*AW +: AW] = 9'(v.wr_mask);
        bus.wr_ovr_addr[v.port*AW +: AW] = 9'(v.wr_addr);
        bus.rd_ovr_mask[v.port*AW +: AW] = 9'(v.rd_mask);
        bus.rd_ovr_addr[v.port*AW +: AW] = 9'(v.rd_addr);
        bus.wr_tid = 9'(v.wr_tid);
        bus.rd_tid = 9'(v.rd_tid);
        for (int c = 0; c <= exp_cyc + 1; c++) begin
            if (c >= 1) begin
                ev = '0;
                if (c == exp_cyc) ev[v.port] = 1'b1;
                if (bus.rd_valid !== ev) bad++;
                if (c == exp_cyc) got = bus.rd_data[v.port];
                if (c == exp_cyc + 1) held = bus.rd_data[v.port];
            end
            bus.wr_en = '0;
            bus.rd_en = '0;
            if (c == 0) begin
                bus.wr_en[v.port]   = 1'b1;
                bus.wr_data[v.port] = 1'(v.wr_data);
            end
            if (c == v.rd_at) bus.rd_en[v.port] = 1'b1;
            tick();
        end
        idle_req();
        clear_cfg();
        check($sformatf("vec%0d_valid_timing", i), 32'(bad), 32'd0);
        check($sformatf("vec%0d_data", i), 32'(got), 32'(v.exp_data));
        check($sformatf("vec%0d_hold", i), 32'(held), 32'(v.exp_data));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int tids [5];
        int dn;

        //         port in out wtid  wd wmask  waddr  rtid    rmask   raddr  at exp
        vecs[0] = '{0,  0, 0, 5,     0, 0,     0,     5,      0,      0,     1, 0};
        vecs[1] = '{7,  3, 2, 9,     0, 0,     0,     9,      0,      0,     3, 0};
        vecs[2] = '{7,  3, 2, 10,    0, 0,     0,     10,     0,      0,     2, 1};
        vecs[3] = '{2,  0, 0, 20,    0, 0,     0,     20,     0,      0,     0, 0};
        vecs[4] = '{4,  7, 7, 33,    0, 0,     0,     33,     0,      0,     7, 0};
        vecs[5] = '{5,  1, 4, 40,    0, 0,     0,     40,     0,      0,     5, 0};
        vecs[6] = '{0,  0, 0, 5,     1, 0,     0,     5,      0,      0,     1, 1};
        vecs[7] = '{1,  0, 0, 'h10,  0, 0,     0,     'h123,  'h1FF,  'h10,  1, 0};
        vecs[8] = '{6,  0, 0, 3,     0, 'h1FF, 'h55,  'h55,   0,      0,     1, 0};
        vecs[9] = '{8,  0, 0, 'h1F5, 0, 0,     0,     'h1F0,  'h00F,  'h005, 1, 0};

        rst = 1'b1;
        idle_req();
        clear_cfg();
        tick();
        tick();
        rst = 1'b0;

        // Reset state and the power-on sweep.
        check("rst_clr_busy", 32'(bus.clr_busy), 32'd1);
        check("rst_clr_done", 32'(bus.clr_done), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        wait_sweep("por", 512, -1);
        tick();
        check("por_done_drop", 32'(bus.clr_done), 32'd0);
        check("por_busy_low", 32'(bus.clr_busy), 32'd0);
        read_all(3, "por_port3_all_ones");

        // Table-driven latency / bypass / override vectors.
        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Full read override: thread id is irrelevant, entry 0x10 of port 1 (=0).
        tids = '{0, 'h10, 'h1FF, 'hAA, 'h155};
        bus.rd_ovr_mask[1*AW +: AW] = 9'h1FF;
        bus.rd_ovr_addr[1*AW +: AW] = 9'h010;
        for (int i = 0; i < 5; i++) begin
            read_one(1, tids[i], 1'b0, $sformatf("ovr_tid%0d", i));
        end
        clear_cfg();
        read_one(1, 0, 1'b1, "ovr_off_entry0");
        read_one(0, 20, 1'b1, "port_isolation");

        // Clear while writes are queued in a 4-deep write delay line.
        write_one(11, 60, 1'b0);
        read_one(11, 60, 1'b0, "pre_clr_entry60");
        bus.input_latency[11*LATW +: LATW] = 3'd4;
        for (int i = 0; i < 3; i++) begin
            write_one(11, 61 + i, 1'b0);
        end
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        check("clr_busy_entry", 32'(bus.clr_busy), 32'd1);
        bus.rd_en = '1;
        wait_sweep("clr", 512, 10);
        bus.rd_en[11] = 1'b1;
        bus.rd_tid    = 9'd61;
        tick();
        bus.rd_en = '0;
        check("done_cycle_read_valid", 32'(bus.rd_valid), 32'h0800);
        check("done_cycle_read_data", 32'(bus.rd_data[11]), 32'd1);
        check("clr_done_drop", 32'(bus.clr_done), 32'd0);
        bus.input_latency = '0;
        tick();
        read_one(11, 60, 1'b1, "clr_entry60");
        read_one(11, 62, 1'b1, "clr_entry62");
        read_one(11, 63, 1'b1, "clr_entry63");
        read_one(11, 2, 1'b1, "clr_entry2_sweep_write_ignored");

        // Reset in the middle of a sweep restarts it from index 0.
        write_one(3, 300, 1'b0);
        read_one(3, 300, 1'b0, "pre_rst_entry300");
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        dn = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.clr_done !== 1'b0) dn++;
            tick();
        end
        check("mid_sweep_busy", 32'(bus.clr_busy), 32'd1);
        check("mid_sweep_no_done", 32'(dn), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_clr_busy", 32'(bus.clr_busy), 32'd1);
        check("rst2_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst2_rd_data", 32'(bus.rd_data), 32'd0);
        wait_sweep("rst_sweep", 512, -1);
        tick();
        check("rst_sweep_done_drop", 32'(bus.clr_done), 32'd0);
        read_one(3, 300, 1'b1, "rst_sweep_entry300");
        read_all(3, "rst_sweep_port3_all_ones");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
